mtrx_addsub_stream: RTL and testbench
=====================================

Name: mtrx_addsub_stream

Overview:
- Parametrised N x N matrix element-wise add/subtract engine. Processes LANES elements per cycle behind a valid/ready handshake.
- Supports signed/unsigned elements and reports overflow.
- Sits between the matrix operand buffers and the result writeback stage of the Gauss core.
- Default configuration is a 5x5, 8-bit, unsigned adder.

Parameters:
- N, 5, matrix dimension (N*N elements).
- ELEM_W, 8, element width in bits.
- LANES, 5, elements processed per cycle, 1..N*N.
- SIGNED, 0, 1 = two's-complement elements, 0 = unsigned.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept a new operation.
- op  in  1  0 = C = A + B, 1 = C = A - B; sampled on accept.
- a  in  N*N*ELEM_W  matrix A, element i at bits [i*ELEM_W +: ELEM_W].
- b  in  N*N*ELEM_W  matrix B, same packing.
- out_valid  out  1  c and overflow hold a complete result.
- out_ready  in  1  consumer takes the result.
- c  out  N*N*ELEM_W  result matrix, same packing.
- overflow  out  1  sticky: set if any element overflowed in this operation.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, c=0, overflow=0, out_valid=0, busy=0, internal operand regs=0, beat counter=0. in_ready=1 once in IDLE. Reset mid-BUSY or mid-DONE aborts the operation; no partial result is ever flagged valid.
- BEATS = ceil(N*N/LANES).
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture a, b, op into internal regs, clear overflow, beat=0, go BUSY.
  - BUSY: in_ready=0, busy=1. Each edge computes elements beat*LANES .. beat*LANES+LANES-1 and writes them into c. Lanes whose index is >= N*N on the final beat are ignored and write nothing. OR any per-element overflow into overflow. After the edge processing beat BEATS-1, go DONE.
  - DONE: out_valid=1, busy=0, in_ready=0. c and overflow are stable. On out_ready, go IDLE with out_valid=0. c and overflow hold their values until the next accept.
- Latency: accept edge k gives out_valid=1 in the cycle after edge k+BEATS. For defaults that is 5 edges.
- Inputs a/b/op may change freely after acceptance; the block works from the captured copies.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- c contents during BUSY are partial and undefined to the consumer.
- Arithmetic is ELEM_W-bit, computed at ELEM_W+1 bits internally.
  - Unsigned overflow: add carry-out, or sub borrow (a<b).
  - Signed overflow: operands share a sign (add) or differ in sign (sub), and the result sign differs from a's sign.
  - Without saturation the result wraps modulo 2^ELEM_W.

Optional Feature:
- Macro MTRX_SAT_EN. When defined, an overflowing element is clamped instead of wrapped:
  - unsigned add clamps to 2^ELEM_W-1; unsigned sub clamps to 0;
  - signed clamps to max positive or min negative according to the true result sign.
- overflow is still reported identically with or without the macro.
- When undefined, results wrap and no clamp logic is generated.

Decomposition:
- Package mtrx_pkg:
  - op encoding constants OP_ADD=0, OP_SUB=1;
  - state enum IDLE/BUSY/DONE;
  - function ceil_div for BEATS;
  - beat counter width = $clog2(BEATS+1).
- Sub-module mtrx_lane_alu: one element add/sub with the overflow detect and MTRX_SAT_EN clamp, parametrised by ELEM_W and SIGNED. Instantiated LANES times via generate.

Test Plan:
- Defaults, a=elements 1..25, b=25..1, op=0, out_ready=1 → out_valid exactly 5 cycles after accept, every element = 26, overflow=0, then in_ready=1 next cycle.
- Defaults unsigned, element0 a=3, b=5, op=1 → wrap build: c[0]=254, overflow=1; MTRX_SAT_EN build: c[0]=0, overflow=1; other elements unaffected.
- SIGNED=1, a=100, b=100 everywhere, op=0 → wrap: -56 (0xC8), overflow=1; MTRX_SAT_EN: 127 (0x7F), overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a/b → c and overflow stable, in_ready=0, second op not accepted until the cycle after out_ready=1.
- N=4, LANES=3 (16 elements, 6 beats, last beat 1 valid lane) → out_valid after 6 edges, all 16 elements correct, no out-of-range write.
- Assert reset=0 during beat 2 of BUSY → c=0, out_valid=0, overflow=0 immediately. After release, a fresh operation completes with correct results.

Source files
------------

// File: rtl/mtrx_pkg.sv
// Shared definitions for the matrix add/subtract stream engine: op encoding,
// controller states and beat-count helper.
package mtrx_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mtrx_lane_alu.sv
// One-element add/subtract with overflow detection. Defining MTRX_SAT_EN
// clamps overflowing results instead of letting them wrap.
module mtrx_lane_alu
    import mtrx_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic              op,
    output logic [ELEM_W-1:0] r,
    output logic              ovf
);

    logic [ELEM_W:0] ext;

    // ext is the exact result at ELEM_W+1 bits, so its top bit is the true sign (or borrow/carry)
    always_comb begin
        if (SIGNED) begin
            if (op == OP_SUB) ext = {a[ELEM_W-1], a} - {b[ELEM_W-1], b};
            else              ext = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
            ovf = ext[ELEM_W] ^ ext[ELEM_W-1];
        end else begin
            if (op == OP_SUB) ext = {1'b0, a} - {1'b0, b};
            else              ext = {1'b0, a} + {1'b0, b};
            ovf = ext[ELEM_W];
        end
        r = ext[ELEM_W-1:0];
`ifdef MTRX_SAT_EN
        if (ovf) begin
            if (SIGNED)              r = ext[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
            else if (op == OP_SUB)   r = '0;
            else                     r = '1;
        end
`endif
    end

endmodule

// File: rtl/mtrx_addsub_stream.sv
// N x N element-wise add/subtract engine, LANES elements per beat, valid/ready
// on both sides. Optional saturation via the MTRX_SAT_EN macro (in mtrx_lane_alu).
module mtrx_addsub_stream
    import mtrx_pkg::*;
#(
    parameter int N      = 5,
    parameter int ELEM_W = 8,
    parameter int LANES  = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op,
    input  logic [N*N*ELEM_W-1:0]   a,
    input  logic [N*N*ELEM_W-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*N*ELEM_W-1:0]   c,
    output logic                    overflow,
    output logic                    busy
);

    localparam int NEL   = N * N;
    localparam int BEATS = ceil_div(NEL, LANES);
    localparam int BW    = $clog2(BEATS + 1);
    localparam int VW    = NEL * ELEM_W;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [VW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic            op_q, op_d, ovf_q, ovf_d;

    int              lane_idx [LANES];
    logic            lane_en  [LANES];
    logic [ELEM_W-1:0] lane_a [LANES];
    logic [ELEM_W-1:0] lane_b [LANES];
    logic [ELEM_W-1:0] lane_r [LANES];
    logic            lane_ovf [LANES];

    // Lanes past the last element on the final beat stay disabled and write nothing
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = int'(beat_q) * LANES + l;
            lane_en[l]  = lane_idx[l] < NEL;
            lane_a[l]   = '0;
            lane_b[l]   = '0;
            if (lane_en[l]) begin
                lane_a[l] = a_q[lane_idx[l]*ELEM_W +: ELEM_W];
                lane_b[l] = b_q[lane_idx[l]*ELEM_W +: ELEM_W];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mtrx_lane_alu #(
            .ELEM_W (ELEM_W),
            .SIGNED (SIGNED)
        ) u_alu (
            .a   (lane_a[l]),
            .b   (lane_b[l]),
            .op  (op_q),
            .r   (lane_r[l]),
            .ovf (lane_ovf[l])
        );
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    ovf_d   = 1'b0;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    if (lane_en[l]) begin
                        c_d[lane_idx[l]*ELEM_W +: ELEM_W] = lane_r[l];
                        ovf_d = ovf_d | lane_ovf[l];
                    end
                end
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mtrx_addsub_stream.sv
// Bench for mtrx_addsub_stream: a 5x5/5-lane unsigned instance and a
// 4x4/3-lane signed instance checked against an integer-arithmetic model.
module tb_mtrx_addsub_stream;

    localparam int BEATS0 = 5;
    localparam int BEATS1 = 6;

`ifdef MTRX_SAT_EN
    localparam logic [7:0] T2_C0    = 8'h00;
    localparam logic [7:0] T3_C     = 8'h7F;
    localparam logic [8:0] PIN_USUB = 9'h100;
    localparam logic [8:0] PIN_SADD = 9'h17F;
    localparam logic [8:0] PIN_SSUB = 9'h180;
`else
    localparam logic [7:0] T2_C0    = 8'hFE;
    localparam logic [7:0] T3_C     = 8'hC8;
    localparam logic [8:0] PIN_USUB = 9'h1FE;
    localparam logic [8:0] PIN_SADD = 9'h1C8;
    localparam logic [8:0] PIN_SSUB = 9'h17F;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iv [2];
    logic ir [2];
    logic opv [2];
    logic ovl [2];
    logic ordy [2];
    logic ofl [2];
    logic bz [2];
    logic [199:0] av [2];
    logic [199:0] bv [2];
    logic [199:0] c0;
    logic [127:0] c1;
    logic [199:0] cv [2];

    int nchk = 0;
    int nerr = 0;
    logic [199:0] exp_c [2] = '{default: '0};
    logic exp_ovf [2] = '{default: 1'b0};
    bit   pend [2] = '{default: 1'b0};
    int   cnt [2] = '{default: 0};

    always #5 clock = ~clock;

    mtrx_addsub_stream #(.N(5), .ELEM_W(8), .LANES(5), .SIGNED(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
        .a(av[0]), .b(bv[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .c(c0),
        .overflow(ofl[0]), .busy(bz[0])
    );

    mtrx_addsub_stream #(.N(4), .ELEM_W(8), .LANES(3), .SIGNED(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
        .a(av[1][127:0]), .b(bv[1][127:0]), .out_valid(ovl[1]), .out_ready(ordy[1]), .c(c1),
        .overflow(ofl[1]), .busy(bz[1])
    );

    assign cv[0] = c0;
    assign cv[1] = {72'b0, c1};

    function automatic void chk(input string nm, input logic [199:0] act, input logic [199:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    // {overflow, result} for one element, from the true integer result
    function automatic logic [8:0] elem(input logic [7:0] x, input logic [7:0] y, input logic o, input logic sgn);
        int xv, yv, t, lo, hi;
        logic [7:0] r;
        logic ov;
        if (sgn) begin
            xv = int'($signed(x)); yv = int'($signed(y)); lo = -128; hi = 127;
        end else begin
            xv = int'(x); yv = int'(y); lo = 0; hi = 255;
        end
        t  = o ? xv - yv : xv + yv;
        ov = (t < lo) || (t > hi);
        r  = t[7:0];
`ifdef MTRX_SAT_EN
        if (t < lo) r = lo[7:0];
        else if (t > hi) r = hi[7:0];
`endif
        return {ov, r};
    endfunction

    function automatic void model(input logic [199:0] a, input logic [199:0] b, input logic o,
                                  input int nel, input logic sgn,
                                  output logic [199:0] c, output logic ovf);
        logic [8:0] e;
        c = '0;
        ovf = 1'b0;
        for (int i = 0; i < nel; i++) begin
            e = elem(a[i*8 +: 8], b[i*8 +: 8], o, sgn);
            c[i*8 +: 8] = e[7:0];
            ovf = ovf | e[8];
        end
    endfunction

    // Compare process: tracks each instance's operation at transaction level
    always @(negedge clock) begin
        if (!reset) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (ovl[s]) begin
                    chk("c", cv[s], exp_c[s]);
                    chk("overflow", ofl[s], exp_ovf[s]);
                    chk("in_ready_done", ir[s], 1'b0);
                    chk("busy_done", bz[s], 1'b0);
                    if (pend[s]) begin
                        chk("latency", cnt[s], (s == 0) ? BEATS0 : BEATS1);
                        pend[s] = 1'b0;
                    end
                end else if (pend[s]) begin
                    chk("busy_busy", bz[s], 1'b1);
                    chk("in_ready_busy", ir[s], 1'b0);
                    cnt[s]++;
                    if (cnt[s] > 40) begin
                        chk("done_timeout", 1'b0, 1'b1);
                        pend[s] = 1'b0;
                    end
                end else begin
                    chk("in_ready_idle", ir[s], 1'b1);
                    chk("busy_idle", bz[s], 1'b0);
                end
                if (iv[s] && ir[s]) begin
                    model(av[s], bv[s], opv[s], (s == 0) ? 25 : 16, s == 1, exp_c[s], exp_ovf[s]);
                    pend[s] = 1'b1;
                    cnt[s]  = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble(input int s);
        for (int i = 0; i < 25; i++) begin
            av[s][i*8 +: 8] = 8'($urandom);
            bv[s][i*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic run_op(input int s, input logic o);
        opv[s] = o;
        iv[s]  = 1'b1;
        for (int k = 0; k < 50 && !ir[s]; k++) step();
        if (!ir[s]) chk("accept_timeout", 1'b0, 1'b1);
        step();
        iv[s]  = 1'b0;
        opv[s] = ~o;
        scramble(s);
    endtask

    task automatic wait_done(input int s);
        for (int k = 0; k < 60 && !ovl[s]; k++) step();
        if (!ovl[s]) chk("wait_done_timeout", 1'b0, 1'b1);
    endtask

    task automatic load_ramp0();
        for (int i = 0; i < 25; i++) begin
            av[0][i*8 +: 8] = 8'(i + 1);
            bv[0][i*8 +: 8] = 8'(25 - i);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; opv[s] = 1'b0; ordy[s] = 1'b1; av[s] = '0; bv[s] = '0;
        end

        chk("model_add26", elem(8'd1, 8'd25, 1'b0, 1'b0), 9'h01A);
        chk("model_usub", elem(8'd3, 8'd5, 1'b1, 1'b0), PIN_USUB);
        chk("model_sadd", elem(8'd100, 8'd100, 1'b0, 1'b1), PIN_SADD);
        chk("model_ssub_min", elem(8'h80, 8'h01, 1'b1, 1'b1), PIN_SSUB);
        chk("model_sadd_zero", elem(8'hFF, 8'h01, 1'b0, 1'b1), 9'h000);

        #2 reset = 1'b0;
        #10;
        for (int s = 0; s < 2; s++) begin
            chk("rst_c", cv[s], '0);
            chk("rst_out_valid", ovl[s], 1'b0);
            chk("rst_overflow", ofl[s], 1'b0);
            chk("rst_busy", bz[s], 1'b0);
            chk("rst_in_ready", ir[s], 1'b1);
        end
        step();
        reset = 1'b1;
        step();

        // all elements sum to 26
        load_ramp0();
        run_op(0, 1'b0);
        wait_done(0);
        chk("t1_c", cv[0], {25{8'd26}});
        chk("t1_ovf", ofl[0], 1'b0);
        step();
        chk("t1_in_ready_after", ir[0], 1'b1);

        // unsigned borrow on element 0 only
        for (int i = 0; i < 25; i++) begin
            av[0][i*8 +: 8] = 8'd9;
            bv[0][i*8 +: 8] = 8'd4;
        end
        av[0][7:0] = 8'd3;
        bv[0][7:0] = 8'd5;
        run_op(0, 1'b1);
        wait_done(0);
        chk("t2_c0", cv[0][7:0], T2_C0);
        chk("t2_c1", cv[0][15:8], 8'd5);
        chk("t2_c24", cv[0][199:192], 8'd5);
        chk("t2_ovf", ofl[0], 1'b1);

        // signed 100 + 100 everywhere
        av[1] = '0; bv[1] = '0;
        for (int i = 0; i < 16; i++) begin
            av[1][i*8 +: 8] = 8'd100;
            bv[1][i*8 +: 8] = 8'd100;
        end
        run_op(1, 1'b0);
        wait_done(1);
        chk("t3_c", cv[1][127:0], {16{T3_C}});
        chk("t3_ovf", ofl[1], 1'b1);

        // 4x4, 3 lanes: c[i] = (i+1) - 2i
        av[1] = '0; bv[1] = '0;
        for (int i = 0; i < 16; i++) begin
            av[1][i*8 +: 8] = 8'(i + 1);
            bv[1][i*8 +: 8] = 8'(2 * i);
        end
        run_op(1, 1'b1);
        wait_done(1);
        chk("t4_c0", cv[1][7:0], 8'h01);
        chk("t4_c15", cv[1][127:120], 8'hF2);
        chk("t4_ovf", ofl[1], 1'b0);

        // backpressure in DONE while inputs churn
        ordy[0] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            av[0][i*8 +: 8] = 8'(i);
            bv[0][i*8 +: 8] = 8'd1;
        end
        run_op(0, 1'b0);
        wait_done(0);
        for (int k = 0; k < 10; k++) begin
            iv[0] = k[0];
            opv[0] = 1'($urandom);
            scramble(0);
            step();
            chk("bp_valid_held", ovl[0], 1'b1);
            chk("bp_in_ready", ir[0], 1'b0);
        end
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        step();
        chk("bp_release_valid", ovl[0], 1'b0);
        chk("bp_release_ready", ir[0], 1'b1);
        step();
        chk("bp_second_busy", bz[0], 1'b1);
        iv[0] = 1'b0;
        wait_done(0);

        // randomized traffic with random backpressure on both instances
        for (int n = 0; n < 1000; n++) begin
            for (int s = 0; s < 2; s++) begin
                iv[s]   = 1'($urandom_range(0, 1));
                opv[s]  = 1'($urandom_range(0, 1));
                ordy[s] = ($urandom_range(0, 3) != 0);
                scramble(s);
            end
            step();
        end
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0;
            ordy[s] = 1'b1;
        end
        repeat (20) step();

        // reset during beat 2 aborts both operations
        load_ramp0();
        for (int i = 0; i < 16; i++) begin
            av[1][i*8 +: 8] = 8'h11;
            bv[1][i*8 +: 8] = 8'h22;
        end
        opv[0] = 1'b0; opv[1] = 1'b0;
        iv[0] = 1'b1; iv[1] = 1'b1;
        step();
        iv[0] = 1'b0; iv[1] = 1'b0;
        step();
        step();
        #1 reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("mid_rst_c", cv[s], '0);
            chk("mid_rst_out_valid", ovl[s], 1'b0);
            chk("mid_rst_overflow", ofl[s], 1'b0);
            chk("mid_rst_busy", bz[s], 1'b0);
        end
        step();
        reset = 1'b1;
        step();

        load_ramp0();
        run_op(0, 1'b0);
        wait_done(0);
        chk("post_rst_c0", cv[0], {25{8'd26}});
        for (int i = 0; i < 16; i++) begin
            av[1][i*8 +: 8] = 8'hFB;
            bv[1][i*8 +: 8] = 8'h03;
        end
        run_op(1, 1'b0);
        wait_done(1);
        chk("post_rst_c1", cv[1][127:0], {16{8'hFE}});
        chk("post_rst_ovf1", ofl[1], 1'b0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
